// File: rtl/jenc_pkg.sv
// Shared constants for the JPEG byte packer / unpacker pair.
// Both sides agree on the stuffing marker bytes and the word/beat geometry.
package jenc_pkg;

    localparam logic [7:0] JPEG_STUFF_BYTE = 8'hFF;
    localparam logic [7:0] JPEG_STUFF_ZERO = 8'h00;
    localparam int         WORD_BYTES      = 16;
    localparam int         BEAT_BYTES      = 8;

    typedef logic [7:0] byte_t;

    // Raw bytes taken from the buffer in one cycle: everything left, capped at one beat.
    function automatic logic [3:0] chunkBytes(input logic [4:0] rem);
        return (rem > 5'(BEAT_BYTES)) ? 4'(BEAT_BYTES) : rem[3:0];
    endfunction

endpackage

// File: rtl/byteunpacker_if.sv
// Input word stream and output beat stream of the byte unpacker.
// The slave modport is the unpacker's view; master is the surrounding logic.
interface byteunpacker_if;

    logic [127:0] in_data;
    logic [4:0]   in_bytes;
    logic         in_tlast;
    logic         in_valid;
    logic         in_hold;

    logic [63:0]  out_data;
    logic [3:0]   out_bytes;
    logic         out_tlast;
    logic         out_valid;
    logic         out_hold;

    modport master (
        output in_data, in_bytes, in_tlast, in_valid,
        input  in_hold,
        input  out_data, out_bytes, out_tlast, out_valid,
        output out_hold
    );

    modport slave (
        input  in_data, in_bytes, in_tlast, in_valid,
        output in_hold,
        output out_data, out_bytes, out_tlast, out_valid,
        input  out_hold
    );

endinterface

// File: rtl/byte_unstuff8.sv
// Combinational destuffer for up to eight raw bytes, MSB-first.
// A 0x00 directly after 0xFF is dropped; kept bytes are packed towards the MSB.
module byte_unstuff8
    import jenc_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [3:0]  n,
    input  logic        prev_ff,
    output logic [63:0] data,
    output logic [3:0]  count,
    output logic        last_ff,
    output logic        err
);

    logic  w_pend;
    byte_t w_byte;

    always_comb begin
        data    = '0;
        count   = '0;
        err     = 1'b0;
        w_pend  = prev_ff;
        w_byte  = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            w_byte = raw[63 - 8*i -: 8];
            if (4'(i) < n) begin
                if (w_pend && (w_byte == JPEG_STUFF_ZERO)) begin
                    w_pend = 1'b0;
                end else begin
                    // Anything other than a stuffed zero after 0xFF is malformed but still forwarded.
                    if (w_pend) begin
                        err = 1'b1;
                    end
                    data[7'd63 - {1'b0, count[2:0], 3'b000} -: 8] = w_byte;
                    count  = count + 4'd1;
                    w_pend = (w_byte == JPEG_STUFF_BYTE);
                end
            end
        end
        last_ff = w_pend;
    end

endmodule

// File: rtl/byteunpacker.sv
// Decode-path byte unpacker: buffers 16-byte words, strips JPEG 0xFF00 stuffing
// and re-emits up to eight bytes per beat, with frame size and stuffing-error reporting.
module byteunpacker
    import jenc_pkg::*;
#(
    parameter int SIZE_W = 20
)
(
    input  logic              clk,
    input  logic              reset,
    byteunpacker_if.slave     bus,
    output logic [SIZE_W-1:0] size,
    input  logic              size_clear,
    output logic              stuff_err
);

    logic [127:0]      r_buf;
    logic [4:0]        r_loaded;
    logic [4:0]        r_rdPtr;
    logic              r_bufTlast;
    logic              r_bufFull;
    logic              r_pendingFf;

    logic [63:0]       r_outData;
    logic [3:0]        r_outBytes;
    logic              r_outTlast;
    logic              r_outValid;

    logic [SIZE_W-1:0] r_count;
    logic [SIZE_W-1:0] r_size;
    logic [1:0]        r_clrSync;
    logic              r_stuffErr;

    logic [4:0]        w_rem;
    logic [3:0]        w_n;
    logic              w_adv;
    logic              w_lastChunk;
    logic              w_inHold;
    logic              w_accept;
    logic              w_drain;
    logic              w_tlastBeat;
    logic              w_emit;
    logic              w_xfer;
    logic [4:0]        w_idx;
    logic [63:0]       w_raw;
    logic [63:0]       w_data;
    logic [3:0]        w_count;
    logic              w_lastFf;
    logic              w_err;

    assign w_rem       = r_loaded - r_rdPtr;
    assign w_n         = chunkBytes(w_rem);
    assign w_adv       = ~r_outValid | ~bus.out_hold;
    assign w_lastChunk = (w_rem <= 5'(BEAT_BYTES));
    // Allowing a load while the final chunk drains keeps 16-byte words at one per two cycles.
    assign w_inHold    = r_bufFull & ~(w_lastChunk & w_adv);
    assign w_accept    = bus.in_valid & ~w_inHold;
    assign w_drain     = r_bufFull & w_adv;
    assign w_tlastBeat = w_lastChunk & r_bufTlast;
    assign w_emit      = w_drain & ((w_count != 4'd0) | w_tlastBeat);
    assign w_xfer      = r_outValid & ~bus.out_hold;

    always_comb begin
        w_raw = '0;
        w_idx = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            w_idx = r_rdPtr + 5'(i);
            if (w_idx < 5'(WORD_BYTES)) begin
                w_raw[63 - 8*i -: 8] = r_buf[7'd127 - {w_idx[3:0], 3'b000} -: 8];
            end
        end
    end

    byte_unstuff8 u_unstuff (
        .raw     (w_raw),
        .n       (w_n),
        .prev_ff (r_pendingFf),
        .data    (w_data),
        .count   (w_count),
        .last_ff (w_lastFf),
        .err     (w_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf       <= '0;
            r_loaded    <= '0;
            r_rdPtr     <= '0;
            r_bufTlast  <= 1'b0;
            r_bufFull   <= 1'b0;
            r_pendingFf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf      <= bus.in_data;
                r_loaded   <= bus.in_bytes;
                r_rdPtr    <= '0;
                r_bufTlast <= bus.in_tlast;
                r_bufFull  <= 1'b1;
            end else if (w_drain) begin
                if (w_lastChunk) begin
                    r_bufFull <= 1'b0;
                end else begin
                    r_rdPtr <= r_rdPtr + {1'b0, w_n};
                end
            end
            // The 0xFF predecessor carries across words but never across frames.
            if (w_drain) begin
                r_pendingFf <= w_tlastBeat ? 1'b0 : w_lastFf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outBytes <= '0;
            r_outTlast <= 1'b0;
        end else if (w_adv) begin
            r_outValid <= w_emit;
            r_outData  <= w_emit ? w_data  : '0;
            r_outBytes <= w_emit ? w_count : '0;
            r_outTlast <= w_emit & w_tlastBeat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stuffErr <= 1'b0;
        end else if (w_drain & (w_err | (w_tlastBeat & w_lastFf))) begin
            r_stuffErr <= 1'b1;
        end
    end

    // size_clear comes from another clock domain, so only its synchronised copy is used.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clrSync <= '0;
            r_count   <= '0;
            r_size    <= '0;
        end else begin
            r_clrSync <= {r_clrSync[0], size_clear};
            if (w_xfer) begin
                if (r_outTlast) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + SIZE_W'(r_outBytes);
                end
            end
            if (r_clrSync[1]) begin
                r_size <= '0;
            end else if (w_xfer & r_outTlast) begin
                r_size <= r_count + SIZE_W'(r_outBytes);
            end
        end
    end

    assign bus.in_hold   = w_inHold;
    assign bus.out_data  = r_outData;
    assign bus.out_bytes = r_outBytes;
    assign bus.out_tlast = r_outTlast;
    assign bus.out_valid = r_outValid;
    assign size          = r_size;
    assign stuff_err     = r_stuffErr;

endmodule
